// File: rtl/imem_loader.sv
// Boot loader: assembles a little-endian word-count header plus program words from a
// byte stream, writes them to instruction memory, and holds the core in reset until done.
module imem_loader #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_rst,
  output logic                  done,
  output logic                  err
);

  localparam int KW = ADDR_WIDTH + 1;
  localparam logic [32:0] CAP = 33'd1 << ADDR_WIDTH;

  typedef enum logic [1:0] {S_LEN, S_DATA, S_DONE, S_ERR} state_t;

  state_t                state_q, state_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [23:0]           acc_q, acc_d;
  logic [KW-1:0]         len_q, len_d;
  logic [KW-1:0]         k_q, k_d;
  logic                  rx_ready_q, rx_ready_d;
  logic                  imem_we_q, imem_we_d;
  logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]           imem_wdata_q, imem_wdata_d;
  logic                  core_rst_q, core_rst_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic        data_end;
  logic        accept;
  logic        last_byte;
  logic [31:0] word_in;

  // The cycle after the final write is spent in S_DATA with k==N; no byte is taken then.
  assign data_end  = (state_q == S_DATA) && (k_q == len_q);
  assign accept    = rx_valid && rx_ready_q && !data_end;
  assign last_byte = accept && (byte_cnt_q == 2'd3);
  assign word_in   = {rx_data, acc_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_LEN;
      byte_cnt_q   <= '0;
      acc_q        <= '0;
      len_q        <= '0;
      k_q          <= '0;
      rx_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_rst_q   <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      acc_q        <= acc_d;
      len_q        <= len_d;
      k_q          <= k_d;
      rx_ready_q   <= rx_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      core_rst_q   <= core_rst_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LEN: begin
        if (last_byte) begin
          if (word_in == 32'd0)             state_d = S_DONE;
          else if ({1'b0, word_in} > CAP)   state_d = S_ERR;
          else                              state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (data_end) state_d = S_DONE;
      end
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    byte_cnt_d   = byte_cnt_q;
    acc_d        = acc_q;
    len_d        = len_q;
    k_d          = k_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;

    if (accept) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      case (byte_cnt_q)
        2'd0:    acc_d[7:0]   = rx_data;
        2'd1:    acc_d[15:8]  = rx_data;
        2'd2:    acc_d[23:16] = rx_data;
        default: acc_d        = '0;
      endcase
    end

    if (last_byte && state_q == S_LEN) begin
      len_d = word_in[KW-1:0];
      k_d   = '0;
    end

    if (last_byte && state_q == S_DATA) begin
      imem_we_d    = 1'b1;
      imem_addr_d  = k_q[ADDR_WIDTH-1:0];
      imem_wdata_d = word_in;
      k_d          = k_q + 1'b1;
    end

    rx_ready_d = (state_d == S_LEN) || (state_d == S_DATA);
    core_rst_d = (state_d != S_DONE);
    done_d     = (state_d == S_DONE);
    err_d      = (state_d == S_ERR);
  end

  assign rx_ready   = rx_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_rst   = core_rst_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory loader that sits directly upstream of the multicycle core. It accepts a little-endian byte stream (a 32-bit word-count header followed by the program words), writes each assembled word into instruction memory, and holds the core in reset until the whole program is resident. When loading completes it releases the core, which then fetches from PC 0.

## Interface
Parameters:
- ADDR_WIDTH, 12, instruction-memory word-address width; capacity is 2**ADDR_WIDTH words.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  incoming program byte.
- rx_valid  in  1  rx_data is valid this cycle.
- rx_ready  out  1  loader can accept a byte; registered.
- imem_we  out  1  instruction-memory write strobe; single-cycle pulse per word.
- imem_addr  out  ADDR_WIDTH  word address for the write.
- imem_wdata  out  32  assembled instruction word.
- core_rst  out  1  reset to the core; high until the load completes.
- done  out  1  load completed successfully; sticky until rst.
- err  out  1  header length exceeded capacity; sticky until rst.

## Operation
- A byte is accepted at a rising edge where rx_valid && rx_ready; all other cycles are ignored.
- Byte order is little-endian throughout: the first byte of a group is bits [7:0] and the fourth byte is bits [31:24].
- States:
  - S_LEN: collect 4 bytes into the 32-bit word count N.
  - S_DATA: collect 4*N bytes.
  - S_DONE: load complete, core released.
  - S_ERR: header rejected.
- S_LEN, on acceptance of the 4th byte:
  - N == 0 -> S_DONE.
  - N > 2**ADDR_WIDTH -> S_ERR.
  - otherwise -> S_DATA, with the word index cleared to 0.
- N is compared as a full 32-bit unsigned value; it is never truncated.
- S_DATA: on acceptance of the 4th byte of word k, the next cycle drives imem_we=1, imem_addr=k and imem_wdata=assembled word. Then k increments.
- When k reaches N after a write, the next state is S_DONE.
- k counts to N, which can be 2**ADDR_WIDTH, so the counter is ADDR_WIDTH+1 bits wide. imem_addr is the low ADDR_WIDTH bits of k; there is no wrap-around write.
- rx_ready is 1 in S_LEN and S_DATA, and 0 in S_DONE and S_ERR. Bytes arriving after completion are not consumed.
- S_DONE: done=1, core_rst=0. The state holds until rst.
- S_ERR: err=1, core_rst stays 1, no memory writes occur. The state holds until rst.
- Reset mid-load: the state returns to S_LEN, all counters and the partial-byte accumulator clear, and core_rst returns to 1. Memory contents already written are not cleared; the next load overwrites them.
- rst and rx_valid in the same cycle: rst wins and the byte is not accepted.

## Timing
- Reset values:
  - rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_rst=1, done=0, err=0.
  - rx_ready rises on the first edge with rst low, and stays high while in S_LEN/S_DATA.
- Word write latency: the last byte of word k is accepted at edge E. imem_we is high for exactly the cycle between E and E+1. After E+1, imem_we=0.
- Final word accepted at edge E: done=1, core_rst=0 and rx_ready=0 all take effect after E+1, in the same edge where imem_we falls. The memory write is therefore complete before the core leaves reset.
- N==0: the 4th header byte is accepted at E; done=1, core_rst=0 and rx_ready=0 after E.
- N too large: the 4th header byte is accepted at E; err=1 and rx_ready=0 after E.
- Maximum throughput: one byte per cycle with rx_valid held high; no bubbles between words.

## Test plan
- Header N=2, then bytes 13 00 00 00 93 00 10 00 streamed back-to-back:
  - writes 0x00000013 @0, then 0x00100093 @1, each a 1-cycle imem_we pulse;
  - done and core_rst change one edge after the second pulse.
- Same stream with rx_valid toggling 1,0,1,0: identical writes and data; the gaps only delay the pulses.
- Header N=0: done=1 and core_rst=0 one edge after the 4th header byte; no imem_we.
- ADDR_WIDTH=2:
  - N=4 fills addresses 0..3 then done;
  - N=5 gives err=1, core_rst=1, rx_ready=0, and no writes, even with further bytes offered.
- rst asserted after 6 data bytes of an N=2 load:
  - outputs return to their reset values;
  - a fresh N=1 load writes address 0 with the new word and completes normally.
- After done: 8 more bytes are offered; rx_ready stays 0, no imem_we, and done/core_rst are unchanged.
